// File: rtl/cla_ram_pkg.sv
// Shared types and constants for the CLA RAM-side iobus responder.
package cla_ram_pkg;

  localparam int unsigned AW_DEF = 10;
  localparam int unsigned LW_DEF = 8;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  // Even-parity bit: makes the total number of ones (data + bit) even.
  function automatic logic even_par(input logic [DW_DEF-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/cla_skid_buf.sv
// Two-entry valid/ready buffer with a registered head (out_data) and one spill slot.
module cla_skid_buf #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] spill;
  logic [1:0]   count_n;
  logic         push;
  logic         pop;

  always_comb begin
    push    = in_valid;
    pop     = out_valid && out_ready;
    count_n = count + 2'(push) - 2'(pop);
  end

  // The producer only pushes into a full buffer on a cycle that also pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      out_valid <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
      out_data  <= '0;
      spill     <= '0;
    end else begin
      count     <= count_n;
      out_valid <= (count_n != 2'd0);
      full      <= (count_n == 2'd2);
      empty     <= (count_n == 2'd0);
      if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
        out_data <= in_data;
      end else if (pop && (count == 2'd2)) begin
        out_data <= spill;
      end
      if (push && (((count == 2'd1) && !pop) || (count == 2'd2))) begin
        spill <= in_data;
      end
    end
  end

endmodule

// File: rtl/cla_ram_server.sv
// RAM-side burst responder for the CLA 32-bit iobus: word memory, burst FSM, skid-buffered read stream.
// Optional build macro CLA_RAM_PARITY_EN adds per-word even parity and a sticky par_err output.
module cla_ram_server
  import cla_ram_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned LW = LW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk_ram,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] ram_iobus,
  output logic          ram_valid,
  input  logic          ram_ready,
  output logic          ram_last,
  output logic          busy
`ifdef CLA_RAM_PARITY_EN
  ,
  output logic          par_err
`endif
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_q;

  state_t        state, state_n;
  logic [AW-1:0] addr, addr_n;
  logic [LW-1:0] cnt, cnt_n;

  logic          issue;
  logic          mem_we;
  logic          rd_v;
  logic          rd_last;
  logic          pop;
  logic          room;
  logic          pipe_n;

  logic [DW:0]   sk_out;
  logic [1:0]    sk_count;
  logic [1:0]    sk_count_n;
  logic          sk_full;
  logic          sk_empty;

  assign ram_iobus = sk_out[DW-1:0];
  assign ram_last  = sk_out[DW];

  // Read pipeline occupancy: a new read may issue only if the buffer can take it next cycle.
  always_comb begin
    pop        = ram_valid && ram_ready;
    sk_count_n = sk_count + 2'(rd_v) - 2'(pop);
    room       = sk_empty
              || (!sk_full && (!rd_v || pop))
              || (sk_full && pop && !rd_v);
  end

  // Burst FSM next-state and strobes.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    cnt_n   = cnt;
    issue   = 1'b0;
    mem_we  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_n  = req_addr;
          cnt_n   = req_len;
          state_n = req_write ? WR : RD;
        end
      end
      RD: begin
        if (room) begin
          issue  = 1'b1;
          addr_n = addr + AW'(1);
          cnt_n  = cnt - LW'(1);
          if (cnt == '0) state_n = IDLE;
        end
      end
      WR: begin
        if (wr_valid && wr_ready) begin
          mem_we = 1'b1;
          addr_n = addr + AW'(1);
          cnt_n  = cnt - LW'(1);
          if (cnt == '0) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    pipe_n = issue || (sk_count_n != 2'd0);
  end

  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      cnt       <= '0;
      rd_v      <= 1'b0;
      rd_last   <= 1'b0;
      req_ready <= 1'b0;
      wr_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      cnt       <= cnt_n;
      rd_v      <= issue;
      if (issue) rd_last <= (cnt == '0);
      req_ready <= (state_n == IDLE) && !pipe_n;
      wr_ready  <= (state_n == WR);
      busy      <= (state_n != IDLE) || pipe_n;
    end
  end

  // Word memory: contents are intentionally not reset.
  always_ff @(posedge clk_ram) begin
    if (mem_we) mem[addr] <= wr_data;
    if (issue)  mem_q     <= mem[addr];
  end

`ifdef CLA_RAM_PARITY_EN
  logic par_mem [DEPTH];
  logic par_q;

  always_ff @(posedge clk_ram) begin
    if (mem_we) par_mem[addr] <= even_par(wr_data);
    if (issue)  par_q         <= par_mem[addr];
  end

  // Sticky parity error, checked as each read word enters the output buffer.
  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else if (rd_v && (even_par(mem_q) != par_q)) begin
      par_err <= 1'b1;
    end
  end
`endif

  cla_skid_buf #(
    .W(DW + 1)
  ) u_skid (
    .clk       (clk_ram),
    .rst_n     (rst_n),
    .in_valid  (rd_v),
    .in_data   ({rd_last, mem_q}),
    .out_valid (ram_valid),
    .out_data  (sk_out),
    .out_ready (ram_ready),
    .full      (sk_full),
    .empty     (sk_empty),
    .count     (sk_count)
  );

endmodule

// File: tb/tb_cla_ram_server.sv
// Directed + randomized bench for cla_ram_server against an array model of the word memory.
module tb_cla_ram_server;

  logic        clk_ram;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [7:0]  req_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [31:0] ram_iobus;
  logic        ram_valid;
  logic        ram_ready;
  logic        ram_last;
  logic        busy;
`ifdef CLA_RAM_PARITY_EN
  logic        par_err;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] ref_mem [1024];

  cla_ram_server dut (
    .clk_ram   (clk_ram),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .ram_iobus (ram_iobus),
    .ram_valid (ram_valid),
    .ram_ready (ram_ready),
    .ram_last  (ram_last),
    .busy      (busy)
`ifdef CLA_RAM_PARITY_EN
    ,
    .par_err   (par_err)
`endif
  );

  initial begin
    clk_ram = 1'b0;
    forever #5 clk_ram = ~clk_ram;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_ram);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [9:0] a, input logic [7:0] l);
    int n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_len   = l;
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    check("cmd_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  // use_seq=1 writes base+i, otherwise random words; the model tracks every accepted word.
  task automatic do_write(input logic [9:0] a, input logic [7:0] l,
                          input logic use_seq, input logic [31:0] base);
    logic [31:0] d;
    logic [9:0]  idx;
    send_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      int n = 0;
      d = use_seq ? base + 32'(i) : $urandom;
      wr_valid = 1'b1;
      wr_data  = d;
      while (!wr_ready && n < 50) begin
        step();
        n++;
      end
      check("wr_ready", 32'(wr_ready), 32'd1);
      step();
      idx = a + 10'(i);
      ref_mem[idx] = d;
      wr_valid = 1'b0;
      if (i < int'(l) && ($urandom % 4) == 0) step();
    end
    wr_valid = 1'b0;
  endtask

  // mode 0: ram_ready always 1 (latency/throughput checked); mode 1: random stalls incl. 5-cycle hold.
  task automatic do_read(input logic [9:0] a, input logic [7:0] l, input int mode);
    int          beat = 0;
    int          k = 0;
    int          first = -1;
    logic        held = 1'b0;
    logic [31:0] hd = '0;
    logic        hl = 1'b0;
    logic [9:0]  idx;
    ram_ready = (mode == 0);
    send_cmd(1'b0, a, l);
    while (beat <= int'(l) && k < 2000) begin
      if (mode == 1) ram_ready = (k >= 3 && k < 8) ? 1'b0 : (($urandom % 3) != 0);
      if (held) begin
        check("stall_valid", 32'(ram_valid), 32'd1);
        check("stall_data", ram_iobus, hd);
        check("stall_last", 32'(ram_last), 32'(hl));
      end
      held = 1'b0;
      if (ram_valid) begin
        if (first < 0) begin
          first = k;
          if (mode == 0) check("latency", 32'(k), 32'd2);
        end
        if (ram_ready) begin
          idx = a + 10'(beat);
          check("rd_data", ram_iobus, ref_mem[idx]);
          check("rd_last", 32'(ram_last), 32'(beat == int'(l)));
          if (mode == 0) check("back2back", 32'(k), 32'(2 + beat));
          beat++;
        end else begin
          held = 1'b1;
          hd   = ram_iobus;
          hl   = ram_last;
        end
      end
      step();
      k++;
    end
    check("rd_count", 32'(beat), 32'(int'(l) + 1));
    ram_ready = 1'b1;
    check("post_busy", 32'(busy), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
    check("post_no_extra", 32'(ram_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    ram_ready = 1'b1;

    // Reset values
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_ram_valid", 32'(ram_valid), 32'd0);
    check("rst_ram_last", 32'(ram_last), 32'd0);
    check("rst_ram_iobus", ram_iobus, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_req_ready", 32'(req_ready), 32'd1);

    // Sequential write then full-rate read-after-write
    do_write(10'h000, 8'd3, 1'b1, 32'hA0);
    do_read(10'h000, 8'd3, 0);

    // Address wrap
    do_write(10'h3FE, 8'd3, 1'b0, 32'h0);
    do_read(10'h3FE, 8'd3, 0);

    // Backpressure
    do_write(10'h040, 8'd7, 1'b0, 32'h0);
    do_read(10'h040, 8'd7, 1);

    // Single word
    do_write(10'h080, 8'd0, 1'b0, 32'h0);
    do_read(10'h080, 8'd0, 0);
    step();
    check("single_quiet", 32'(ram_valid), 32'd0);

    // Reset on the 3rd word of a 16-word burst
    do_write(10'h100, 8'd15, 1'b0, 32'h0);
    ram_ready = 1'b1;
    send_cmd(1'b0, 10'h100, 8'd15);
    begin
      int beat = 0;
      int k = 0;
      while (k < 50) begin
        if (ram_valid) begin
          if (beat == 2) break;
          beat++;
        end
        step();
        k++;
      end
      check("mid_reached", 32'(beat), 32'd2);
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ram_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) step();
    check("mid_rst_hold", 32'(ram_valid), 32'd0);
    rst_n = 1'b1;
    step();
    do_read(10'h100, 8'd1, 0);

    // Randomized bursts with random stalls
    for (int r = 0; r < 5; r++) begin
      logic [9:0] a;
      logic [7:0] l;
      a = 10'($urandom);
      l = 8'($urandom % 16);
      do_write(a, l, 1'b0, 32'h0);
      do_read(a, l, 1);
    end

`ifdef CLA_RAM_PARITY_EN
    do_write(10'h010, 8'd1, 1'b0, 32'h0);
    do_read(10'h011, 8'd0, 0);
    check("par_clean", 32'(par_err), 32'd0);
    dut.mem[16] = dut.mem[16] ^ 32'h0000_0020;
    ref_mem[16] = ref_mem[16] ^ 32'h0000_0020;
    do_read(10'h010, 8'd0, 0);
    check("par_set", 32'(par_err), 32'd1);
    do_read(10'h011, 8'd0, 0);
    check("par_sticky", 32'(par_err), 32'd1);
    rst_n = 1'b0;
    #1;
    check("par_rst", 32'(par_err), 32'd0);
    rst_n = 1'b1;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cla_ram_server.md
Name: cla_ram_server

Overview:
- RAM-side responder for the CLA 32-bit RAM iobus. It is the other end of the bus the accelerator core reads feature and weight words from.
- Accepts burst read/write commands, holds an internal synchronous word memory, and streams read data onto ram_iobus with valid/ready flow control and a last marker.
- Lives in the clk_ram domain; the core-side CDC is outside this block.

Parameters:
- AW, 10, word-address width; memory depth = 2**AW words
- LW, 8, burst-length field width; burst = req_len+1 words (1..256)
- DW, 32, data width; fixed to the ram_iobus width

Ports:
- clk_ram  in  1  RAM-domain clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid&&req_ready
- req_write  in  1  1=write burst, 0=read burst
- req_addr  in  AW  start word address
- req_len  in  LW  burst length minus one
- wr_valid  in  1  write data valid
- wr_ready  out  1  write data accepted
- wr_data  in  DW  write word
- ram_iobus  out  DW  read data to the CLA core
- ram_valid  out  1  ram_iobus holds a valid word
- ram_ready  in  1  core accepts the word
- ram_last  out  1  final word of the read burst
- busy  out  1  burst in progress or output buffer non-empty

Behaviour:
- Reset (async, rst_n=0) values: req_ready=0, wr_ready=0, ram_valid=0, ram_last=0, ram_iobus=0, busy=0.
- Reset also sets the FSM to IDLE, clears the counters and empties the skid buffer.
- Memory contents are not reset.
- Reset mid-burst aborts the burst immediately; no further words are emitted.
- FSM states: IDLE, RD, WR.
  - IDLE: req_ready=1 only when the output buffer is empty. On handshake, latch addr and cnt=req_len, then go to RD or WR per req_write.
  - RD: issue one memory read per cycle when the skid buffer has room for the in-flight word. Increment addr and decrement cnt. After issuing the word with cnt==0, return to IDLE.
  - WR: wr_ready=1. Each wr_valid&&wr_ready writes mem[addr]=wr_data, then addr++ and cnt--. After the word with cnt==0 is written, return to IDLE.
- Address arithmetic is modulo 2**AW: a burst wraps from 2**AW-1 to 0.
- Read latency: command handshake at cycle N gives the first ram_valid at cycle N+2 (1-cycle memory plus a registered output).
- Sustained throughput is 1 word/cycle while ram_ready=1.
- Backpressure: ram_valid stays high and ram_iobus/ram_last stay stable until ram_ready.
- A 2-entry skid buffer absorbs the in-flight read, so no word is ever dropped or duplicated.
- ram_last=1 on exactly the (req_len+1)-th word of a read burst.
- Read-after-write: a read command accepted the cycle after the final write handshake returns the new data.
- req_ready=0 in RD/WR. A new command is never accepted while the previous read still has unconsumed words.
- wr_valid is ignored outside WR.
- busy = (state!=IDLE) || buffer non-empty.

Optional Feature:
- Macro: CLA_RAM_PARITY_EN.
- When defined:
  - Each stored word carries an extra even-parity bit computed on write.
  - Reads recompute parity. A mismatch sets the sticky output par_err (1 bit, reset 0), cleared only by rst_n.
  - Port par_err exists only in this build.
- When undefined: no parity storage, no par_err port. Memory width is exactly DW.

Decomposition:
- Package cla_ram_pkg: state enum (IDLE/RD/WR), default AW/LW/DW constants, and a parity function used under the macro.
- One sub-module: cla_skid_buf, a 2-entry valid/ready buffer of width DW+1 (data plus last), with full/empty and count outputs.
- FSM, counters and memory stay in cla_ram_server.

Test Plan:
- Write burst: addr=0x000, len=3, data 0xA0..0xA3. Then read the same burst with ram_ready=1 -> words 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, first ram_valid 2 cycles after the command handshake, ram_last only on 0xA3.
- Wrap: write 4 words at addr=0x3FE. Reading back 0x3FE len=3 -> order mem[0x3FE],mem[0x3FF],mem[0x000],mem[0x001].
- Backpressure: 8-word read with ram_ready toggled randomly (including held low 5 cycles) -> all 8 words delivered in order, no loss or duplicates, data stable while stalled.
- Single word: len=0 read -> exactly one ram_valid beat with ram_last=1. busy falls the cycle after acceptance. req_ready returns to 1.
- Reset mid-read: assert rst_n=0 on the 3rd word of a 16-word burst -> ram_valid=0 and busy=0 immediately. After release, a new len=1 read returns correct data.
- CLA_RAM_PARITY_EN: force a bit flip in stored word 0x010 via the bench backdoor, then read it -> par_err rises and stays 1 until reset. Other words read with par_err unchanged.
